// File: rtl/gfx256_wbm_readwrite.sv
// gfx256_wbm_readwrite: single-transfer Wishbone B3 classic master with bus timeout and error return
module gfx256_wbm_readwrite #(
  parameter int WID = 256,
  parameter int TIMEOUT = 1023,
  localparam int LSB = $clog2(WID/8),
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              read_request_i,
  input  logic              write_request_i,
  input  logic [31-LSB:0]   adr_i,
  input  logic              we_i,
  input  logic [WID/8-1:0]  sel_i,
  input  logic [WID-1:0]    wdat_i,
  output logic [WID-1:0]    rdat_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [2:0]        wb_cti_o,
  output logic [1:0]        wb_bte_o,
  output logic              wb_we_o,
  output logic [WID/8-1:0]  wb_sel_o,
  output logic [31:0]       wb_adr_o,
  output logic [WID-1:0]    wb_dat_o,
  input  logic [WID-1:0]    wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);
  typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic tmo, done, fail;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;
  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT-1));
  assign done = wb_err_i || wb_ack_i || tmo;
  // termination without a slave ack is either a slave error or a timeout
  assign fail = wb_err_i || !wb_ack_i;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      rdat_o <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: if (read_request_i || write_request_i) begin
          state <= BUS;
          cnt <= '0;
          busy_o <= 1'b1;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o <= write_request_i & we_i;
          wb_adr_o <= {adr_i, {LSB{1'b0}}};
          wb_sel_o <= sel_i;
          wb_dat_o <= wdat_i;
        end
        BUS: if (done) begin
          state <= ACK;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          wb_we_o <= 1'b0;
          ack_o <= 1'b1;
          err_o <= fail;
          if (!wb_we_o) rdat_o <= fail ? '0 : wb_dat_i;
        end else cnt <= cnt + CW'(1);
        default: begin
          state <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_gfx256_wbm_readwrite.sv
// tb_gfx256_wbm_readwrite: table-driven transfers plus directed back-to-back, protocol-drop and reset-in-bus sequences
module tb_gfx256_wbm_readwrite;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic read_request_i = 1'b0, write_request_i = 1'b0, we_i = 1'b0;
  logic [26:0] adr_i = '0;
  logic [31:0] sel_i = '0;
  logic [255:0] wdat_i = '0, rdat_o, wb_dat_o, wb_dat_i = '0;
  logic ack_o, err_o, busy_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0] wb_cti_o;
  logic [1:0] wb_bte_o;
  logic [31:0] wb_sel_o, wb_adr_o;
  logic wb_ack_i = 1'b0, wb_err_i = 1'b0;
  int checks = 0, failures = 0, acks = 0;
  gfx256_wbm_readwrite #(.WID(256), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .read_request_i(read_request_i), .write_request_i(write_request_i),
    .adr_i(adr_i), .we_i(we_i), .sel_i(sel_i), .wdat_i(wdat_i),
    .rdat_o(rdat_o), .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (ack_o === 1'b1) acks <= acks + 1;
  typedef struct {
    string name;
    logic rd, wr, we;
    logic [26:0] adr;
    logic [31:0] sel;
    logic [255:0] wdat;
    int waits;
    logic ack, err;
    logic [255:0] sdat;
    logic [31:0] eadr;
    logic ewe, eerr;
    logic [255:0] erdat;
    int ecyc;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int n, a0;
    a0 = acks;
    @(negedge clk_i);
    read_request_i = v.rd; write_request_i = v.wr; we_i = v.we;
    adr_i = v.adr; sel_i = v.sel; wdat_i = v.wdat;
    n = 0;
    @(negedge clk_i);
    while (wb_cyc_o && n < 20) begin
      n++;
      chk({v.name, ".bus"}, {wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, busy_o, ack_o},
          {1'b1, v.ewe, v.eadr, v.sel, 1'b1, 1'b0});
      chk({v.name, ".wdat"}, wb_dat_o, v.wdat);
      wb_ack_i = v.ack && (n == v.waits + 1);
      wb_err_i = v.err && (n == v.waits + 1);
      wb_dat_i = v.sdat;
      @(negedge clk_i);
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    chk({v.name, ".ncyc"}, n, v.ecyc);
    chk({v.name, ".ack"}, {ack_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, busy_o}, {1'b1, v.eerr, 4'b0001});
    chk({v.name, ".rdat"}, rdat_o, v.erdat);
    read_request_i = 1'b0; write_request_i = 1'b0;
    @(negedge clk_i);
    chk({v.name, ".idle"}, {ack_o, err_o, busy_o, wb_cyc_o}, 4'b0000);
    chk({v.name, ".nack"}, acks - a0, 1);
    chk({v.name, ".hold"}, rdat_o, v.erdat);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int a0;
    vecs[0] = '{"rd0", 1, 0, 0, 27'h0000123, 32'hFFFFFFFF, 256'h0, 0, 1, 0, {32{8'hA5}},
                32'h00002460, 0, 0, {32{8'hA5}}, 1};
    vecs[1] = '{"wr3", 0, 1, 1, 27'h0000040, 32'h0000000F, 256'h1234, 3, 1, 0, 256'hDEAD,
                32'h00000800, 1, 0, {32{8'hA5}}, 4};
    vecs[2] = '{"errack", 1, 0, 0, 27'h0000007, 32'h000000FF, 256'h0, 1, 1, 1, 256'hBEEF,
                32'h000000E0, 0, 1, 256'h0, 2};
    vecs[3] = '{"rd2", 1, 0, 1, 27'h7FFFFFF, 32'h80000001, 256'h0, 2, 1, 0, {8{32'hCAFEF00D}},
                32'hFFFFFFE0, 0, 0, {8{32'hCAFEF00D}}, 3};
    vecs[4] = '{"tmo", 1, 0, 0, 27'h0000001, 32'h00000001, 256'h0, 0, 0, 0, 256'h55,
                32'h00000020, 0, 1, 256'h0, 4};
    vecs[5] = '{"rd77", 1, 0, 0, 27'h0000002, 32'h00000003, 256'h0, 0, 1, 0, 256'h77,
                32'h00000040, 0, 0, 256'h77, 1};
    vecs[6] = '{"wrerr", 0, 1, 1, 27'h0000003, 32'h0000F000, 256'h99, 1, 0, 1, 256'h11,
                32'h00000060, 1, 1, 256'h77, 2};
    vecs[7] = '{"both", 1, 1, 1, 27'h0000010, 32'hF0F0F0F0, 256'hABCD, 0, 1, 0, 256'h22,
                32'h00000200, 1, 0, 256'h77, 1};
    repeat (3) @(negedge clk_i);
    chk("rst_ctl", {wb_cyc_o, wb_stb_o, wb_we_o, ack_o, err_o, busy_o, wb_cti_o, wb_bte_o}, 11'd0);
    chk("rst_sel_adr", {wb_sel_o, wb_adr_o}, 64'd0);
    chk("rst_dat", wb_dat_o, 256'd0);
    chk("rst_rdat", rdat_o, 256'd0);
    rst_i = 1'b0;
    // slave strobes while idle must not produce a completion
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("idle_ign", {ack_o, err_o, busy_o, wb_cyc_o}, 4'b0000);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    // back-to-back: request held through ACK, second cycle starts three cycles after the first
    a0 = acks;
    @(negedge clk_i);
    read_request_i = 1'b1; adr_i = 27'h0000100; sel_i = 32'h1;
    @(negedge clk_i);
    chk("b2b_c1", {wb_cyc_o, wb_adr_o}, {1'b1, 32'h00002000});
    wb_ack_i = 1'b1; wb_dat_i = 256'h1111;
    @(negedge clk_i);
    chk("b2b_c2", {ack_o, wb_cyc_o, rdat_o}, {1'b1, 1'b0, 256'h1111});
    wb_ack_i = 1'b0; adr_i = 27'h0000200;
    @(negedge clk_i);
    chk("b2b_c3", {ack_o, busy_o, wb_cyc_o}, 3'b000);
    @(negedge clk_i);
    chk("b2b_c4", {wb_cyc_o, wb_adr_o}, {1'b1, 32'h00004000});
    wb_ack_i = 1'b1; wb_dat_i = 256'h2222;
    @(negedge clk_i);
    chk("b2b_c5", {ack_o, wb_cyc_o, rdat_o}, {1'b1, 1'b0, 256'h2222});
    wb_ack_i = 1'b0; read_request_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_nack", acks - a0, 2);
    // request dropped mid-cycle: transfer still completes
    read_request_i = 1'b1; adr_i = 27'h0000005;
    @(negedge clk_i);
    read_request_i = 1'b0;
    chk("drop_c1", wb_cyc_o, 1'b1);
    @(negedge clk_i);
    chk("drop_c2", {wb_cyc_o, ack_o}, 2'b10);
    wb_ack_i = 1'b1; wb_dat_i = 256'h3333;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    chk("drop_ack", {ack_o, err_o, rdat_o}, {2'b10, 256'h3333});
    @(negedge clk_i);
    // reset in the second bus cycle of a stalled write
    a0 = acks;
    write_request_i = 1'b1; we_i = 1'b1; adr_i = 27'h0000009; wdat_i = 256'h4444;
    @(negedge clk_i);
    chk("rstbus_c1", {wb_cyc_o, wb_we_o}, 2'b11);
    @(negedge clk_i);
    chk("rstbus_c2", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b111);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rstbus_drop", {wb_cyc_o, wb_stb_o, wb_we_o, ack_o, busy_o}, 5'b00000);
    rst_i = 1'b0; write_request_i = 1'b0;
    @(negedge clk_i);
    chk("rstbus_idle", {wb_cyc_o, ack_o, busy_o, rdat_o}, 259'd0);
    chk("rstbus_nack", acks - a0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gfx256_wbm_readwrite.md
Name: gfx256_wbm_readwrite

Overview:
Single Wishbone B3 classic master that drives the gfx256 memory port. It sits directly downstream of the read/write arbiter and takes one arbitrated read or write request at a time. It runs one Wishbone cycle per request and returns a one-cycle acknowledge plus read data to the arbiter. A bus-timeout counter and slave error handling guarantee that no requester can hang.

Parameters:
WID, 256, data width in bits (32/64/128/256); LSB = log2(WID/8)
TIMEOUT, 1023, max BUS-state cycles before forced termination; 0 = timeout disabled

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
read_request_i  in  1  arbiter read request, held until ack_o
write_request_i  in  1  arbiter write request, held until ack_o
adr_i  in  32-LSB  word address [31:LSB]
we_i  in  1  write enable qualifier (valid with write_request_i)
sel_i  in  WID/8  byte selects
wdat_i  in  WID  write data
rdat_o  out  WID  read data to arbiter
ack_o  out  1  one-cycle completion pulse
err_o  out  1  one-cycle pulse coincident with ack_o on error/timeout
busy_o  out  1  high whenever state != IDLE
wb_cyc_o  out  1  Wishbone CYC
wb_stb_o  out  1  Wishbone STB
wb_cti_o  out  3  always 3'b000
wb_bte_o  out  2  always 2'b00
wb_we_o  out  1  Wishbone WE
wb_sel_o  out  WID/8  Wishbone SEL
wb_adr_o  out  32  byte address {adr_i, LSB zeros}
wb_dat_o  out  WID  Wishbone write data
wb_dat_i  in  WID  Wishbone read data
wb_ack_i  in  1  Wishbone ACK
wb_err_i  in  1  Wishbone ERR

Behaviour:
- Reset: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, ack_o, err_o, busy_o = 0; wb_sel_o, wb_adr_o, wb_dat_o, rdat_o = 0; timeout counter = 0.
- Control outputs are registered. There is no combinational path from Wishbone inputs to ack_o.
- FSM states: IDLE, BUS, ACK.
- IDLE: if write_request_i or read_request_i is high, latch adr/sel/wdat and set wb_we_o = write_request_i & we_i. Raise cyc/stb on the next edge, clear the counter, and go to BUS.
  - If both requests are high, the write wins (wb_we_o = we_i).
  - wb_ack_i/wb_err_i seen in IDLE is ignored.
- BUS: cyc/stb and the latched address/sel/data are held stable.
  - wb_err_i=1 → error termination. err_i takes precedence over a simultaneous ack_i.
  - else wb_ack_i=1 → normal termination. For a read, rdat_o <= wb_dat_i.
  - else if TIMEOUT != 0 and counter == TIMEOUT-1 → error termination.
  - else counter++.
  - On any termination: next edge drops cyc/stb/we, pulses ack_o = 1 (err_o = 1 if error), and goes to ACK.
  - Error on a read loads rdat_o = 0. rdat_o is unchanged on writes.
- ACK: ack_o/err_o high for exactly this cycle, then go to IDLE. Requests are not sampled in ACK, because the requester's request is still high this cycle.
- rdat_o holds its value until the next completed read.
- Latency: request seen in cycle 0 → cyc/stb in cycle 1 → zero-wait ack_i in cycle 1 → ack_o in cycle 2 → IDLE in cycle 3.
  - Minimum 3 cycles per transfer.
  - ack_o occurs 1 cycle after the slave ack.
- Request drop while in BUS (protocol violation): the Wishbone cycle still completes and ack_o still pulses.
- rst_i mid-BUS: cyc/stb go low on that edge, no ack_o is issued, and the in-flight transfer is abandoned.
- Counter width is clog2(TIMEOUT+1). It never wraps, because the terminate condition is checked before the increment.

Test Plan:
- Read, zero wait: read_request_i=1, adr_i=27'h0000123 → cyc/stb in cycle 1, wb_adr_o=32'h00002460, we=0. wb_ack_i in cycle 1 with wb_dat_i=256'hA5..A5 → ack_o in cycle 2, rdat_o=A5..A5, err_o=0, busy_o low in cycle 3.
- Write, 3 wait states: write_request_i=1, we_i=1, sel_i=32'h0000000F, wdat_i=256'h1234 → wb_we_o=1, wb_sel_o=32'h0F, wb_dat_o=256'h1234 stable for 4 cycles. ack_i on the 4th cycle → single ack_o pulse, rdat_o unchanged.
- Error: read, wb_err_i=1 and wb_ack_i=1 in the same cycle → ack_o=1, err_o=1, rdat_o=0.
- Timeout with TIMEOUT=4: read with no slave response → cyc held exactly 4 cycles, then ack_o=1, err_o=1, cyc=0.
- Back-to-back: request held through ACK, new request presented in the following IDLE cycle → exactly one ack_o per transfer, second cyc starts 3 cycles after the first.
- Reset in BUS: assert rst_i in cycle 2 of a stalled write → cyc/stb/we=0 on the next edge, no ack_o, state IDLE, busy_o=0.
